// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter with a byte FIFO.
//
// Registers (full 32-bit address compare, other addresses ignored / read 0):
//   BASE+0  DATA    write: push write_data[7:0] (any access size); reads 0
//   BASE+4  STATUS  read: {busy, full, empty, overflow, count[8:4]}; a read
//                   clears the sticky overflow bit
//   BASE+8  DIV     read/write bits [15:0], word writes only, min value 2
//
// Ports:
//   clk            rising-edge clock (bus domain)
//   reset          asynchronous active-high reset
//   write_mem      bus write strobe
//   write_address  bus write byte address
//   write_data     bus write data
//   funct3         access size (000/100 byte, 001/101 half, 010 word)
//   read_address   bus read byte address
//   read_data      registered read data, one cycle after read_address
//   tx             registered serial output, idle high (8N1, LSB first)
module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          BAUD_DIV   = 104,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_mem,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] A_DATA = BASE_ADDR;
  localparam logic [31:0] A_STAT = BASE_ADDR + 32'd4;
  localparam logic [31:0] A_DIV  = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // state
  state_t          r_state;
  logic [15:0]     r_div;
  logic [15:0]     r_bdiv;     // divider frozen for the frame in flight
  logic [15:0]     r_cyc;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [31:0]     r_rdata;

  // combinational
  state_t          w_state_nxt;
  logic [15:0]     w_bdiv_nxt;
  logic [15:0]     w_cyc_nxt;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      w_shift_nxt;
  logic            w_tx_nxt;
  logic            w_pop;
  logic            w_push;
  logic            w_wr_data;
  logic            w_wr_div;
  logic            w_full;
  logic            w_empty;
  logic            w_ovf_evt;
  logic            w_stat_rd;
  logic            w_bit_end;
  logic [15:0]     w_div_wval;
  logic [4:0]      w_cnt5;
  logic [31:0]     w_status;
  logic [31:0]     w_rdata_nxt;
  logic            w_unused;

  assign w_unused = ^write_data[31:16];

  // ---------------------------------------------------------------- decode
  assign w_wr_data  = write_mem && (write_address == A_DATA);
  assign w_wr_div   = write_mem && (write_address == A_DIV) && (funct3 == 3'b010);
  assign w_stat_rd  = (read_address == A_STAT);
  assign w_div_wval = (write_data[15:0] < 16'd2) ? 16'd2 : write_data[15:0];

  // ------------------------------------------------------------------ fifo
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // a pop on the same edge frees a slot, so a push into a full FIFO still lands
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_ovf_evt = w_wr_data && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= write_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // a new overflow on the clearing read edge wins
      r_ovf <= (r_ovf && !w_stat_rd) || w_ovf_evt;
    end
  end

  // ------------------------------------------------------------ div / read
  assign w_cnt5   = 5'(r_count);
  assign w_status = {23'd0, w_cnt5, r_ovf, w_empty, w_full, (r_state != S_IDLE)};

  always_comb begin
    w_rdata_nxt = 32'd0;
    if (read_address == A_STAT)     w_rdata_nxt = w_status;
    else if (read_address == A_DIV) w_rdata_nxt = {16'd0, r_div};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= 16'(BAUD_DIV);
      r_rdata <= 32'd0;
    end else begin
      if (w_wr_div) r_div <= w_div_wval;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign read_data = r_rdata;

  // ------------------------------------------------------------------- fsm
  assign w_bit_end = (r_cyc == r_bdiv - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bdiv  <= 16'(BAUD_DIV);
      r_cyc   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bdiv  <= w_bdiv_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // tx is driven from the next-state decision so each level appears on the
  // same edge the state enters, keeping the output a plain flop.
  always_comb begin
    w_state_nxt = r_state;
    w_bdiv_nxt  = r_bdiv;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_bdiv_nxt  = r_div;
          w_cyc_nxt   = 16'd0;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cyc_nxt   = 16'd0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_cyc_nxt = r_cyc + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cyc_nxt   = 16'd0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end else begin
          w_cyc_nxt = r_cyc + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cyc_nxt   = 16'd0;
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cyc_nxt = r_cyc + 16'd1;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph. Drives the bus on falling edges and
// samples tx / read_data on falling edges; expected waveforms and register
// values are computed here from the register map and 8N1 framing.
module tb_uart_tx_periph;

  localparam logic [31:0] BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_DIV  = BASE + 32'd8;
  localparam logic [31:0] A_IDLE = BASE + 32'd12;

  logic        clk;
  logic        reset;
  logic        write_mem;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        tx;

  int n_cmp;
  int n_bad;

  uart_tx_periph dut (
    .clk          (clk),
    .reset        (reset),
    .write_mem    (write_mem),
    .write_address(write_address),
    .write_data   (write_data),
    .funct3       (funct3),
    .read_address (read_address),
    .read_data    (read_data),
    .tx           (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // all bus tasks start and end just after a falling edge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    write_mem     = 1'b1;
    write_address = a;
    write_data    = d;
    funct3        = f;
    @(negedge clk);
    write_mem     = 1'b0;
    write_address = A_IDLE;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    read_address = a;
    @(negedge clk);
    chk(tag, read_data, exp);
    read_address = A_IDLE;
  endtask

  // Waits for a start bit, then compares the whole frame against 8N1 at div.
  // gap = high samples seen before the start bit; errs = -1 on timeout.
  task automatic rx_frame(input int div, input logic [7:0] b, output int gap, output int errs);
    logic lvl;
    logic found;
    gap   = 0;
    errs  = 0;
    found = 1'b0;
    while (!found && gap < 2000) begin
      @(negedge clk);
      if (tx == 1'b0) found = 1'b1;
      else gap++;
    end
    if (!found) begin
      errs = -1;
      return;
    end
    for (int i = 1; i < 10 * div; i++) begin
      @(negedge clk);
      if (i < div)          lvl = 1'b0;
      else if (i < 9 * div) lvl = b[(i - div) / div];
      else                  lvl = 1'b1;
      if (tx !== lvl) errs++;
    end
  endtask

  int gaps [10];
  int errs [10];
  int g, e, w, lows;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    write_mem = 1'b0;
    write_address = A_IDLE;
    write_data = 32'd0;
    funct3 = 3'b010;
    read_address = A_IDLE;

    // asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // first access right after release; DIV clamps to 2, non-word ignored
    bus_wr(A_DIV, 32'd0, 3'b010);
    rd_chk("div_min2", A_DIV, 32'd2);
    bus_wr(A_DIV, 32'd10, 3'b000);
    rd_chk("div_byte_ign", A_DIV, 32'd2);
    rd_chk("st_reset", A_STAT, 32'h04);
    chk("tx_idle", 32'(tx), 32'd1);

    // single 0x55 frame at DIV 4
    bus_wr(A_DIV, 32'd4, 3'b010);
    rd_chk("div4", A_DIV, 32'd4);
    bus_wr(A_DATA, 32'h55, 3'b000);
    rx_frame(4, 8'h55, g, e);
    chk("f55_latency", g, 32'd0);
    chk("f55_wave", e, 32'd0);
    rd_chk("st_last_stop", A_STAT, 32'h05);
    rd_chk("st_after55", A_STAT, 32'h04);

    // 9 bytes while the first frame is in flight
    fork
      begin
        for (int k = 1; k <= 9; k++) bus_wr(A_DATA, 32'(k), 3'b000);
      end
      begin
        for (int k = 1; k <= 9; k++) rx_frame(4, 8'(k), gaps[k], errs[k]);
      end
    join
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("burst_wave%0d", k), errs[k], 32'd0);
      if (k > 1) chk($sformatf("burst_gap%0d", k), gaps[k], 32'd1);
    end
    @(negedge clk);
    rd_chk("st_burst_done", A_STAT, 32'h04);

    // stall the FSM, then overfill the FIFO
    bus_wr(A_DIV, 32'h0000_FFFF, 3'b010);
    bus_wr(A_DATA, 32'hEE, 3'b000);
    for (int k = 0; k < 9; k++) bus_wr(A_DATA, 32'h10 + 32'(k), 3'b000);
    rd_chk("st_full_ovf", A_STAT, 32'h8B);
    rd_chk("st_ovf_clr", A_STAT, 32'h83);
    // overflow on the clearing edge stays set
    write_mem = 1'b1; write_address = A_DATA; write_data = 32'h99; funct3 = 3'b000;
    read_address = A_STAT;
    @(negedge clk);
    write_mem = 1'b0; write_address = A_IDLE; read_address = A_IDLE;
    chk("st_ovf_same_edge", read_data, 32'h83);
    rd_chk("st_ovf_kept", A_STAT, 32'h8B);
    bus_wr(A_STAT, 32'hFFFF_FFFF, 3'b010);
    rd_chk("st_wr_ignored", A_STAT, 32'h83);
    rd_chk("div_ffff", A_DIV, 32'h0000_FFFF);

    // reset during a stalled frame restores defaults
    #2 reset = 1'b1;
    #1;
    chk("rst2_tx", 32'(tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("st_rst2", A_STAT, 32'h04);
    rd_chk("div_rst2", A_DIV, 32'd104);

    // DIV change mid-frame applies from the next frame
    bus_wr(A_DIV, 32'd4, 3'b010);
    fork
      begin
        bus_wr(A_DATA, 32'hA5, 3'b000);
        bus_wr(A_DATA, 32'h3C, 3'b000);
        repeat (10) @(negedge clk);
        bus_wr(A_DIV, 32'd8, 3'b010);
      end
      begin
        rx_frame(4, 8'hA5, gaps[0], errs[0]);
        rx_frame(8, 8'h3C, gaps[1], errs[1]);
      end
    join
    chk("divchg_f1", errs[0], 32'd0);
    chk("divchg_f2", errs[1], 32'd0);
    chk("divchg_gap", gaps[1], 32'd1);
    @(negedge clk);
    rd_chk("div8", A_DIV, 32'd8);
    rd_chk("st_divchg", A_STAT, 32'h04);

    // reset during data bit 3 with 3 bytes queued
    bus_wr(A_DIV, 32'd4, 3'b010);
    fork
      begin
        bus_wr(A_DATA, 32'h07, 3'b000);
        bus_wr(A_DATA, 32'h11, 3'b000);
        bus_wr(A_DATA, 32'h22, 3'b000);
        bus_wr(A_DATA, 32'h33, 3'b000);
      end
      begin
        w = 0;
        while (tx !== 1'b0 && w < 200) begin
          @(negedge clk);
          w++;
        end
        chk("bit3_start_seen", 32'(w < 200), 32'd1);
        repeat (17) @(negedge clk);
      end
    join
    chk("bit3_low", 32'(tx), 32'd0);
    read_address = A_DIV;
    @(negedge clk);
    chk("bit3_div_rd", read_data, 32'd4);
    chk("bit3_still_low", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst3_tx_async", 32'(tx), 32'd1);
    chk("rst3_rdata_async", read_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    read_address = A_IDLE;
    rd_chk("st_rst3", A_STAT, 32'h04);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("rst3_no_tx", lows, 32'd0);

    // unmapped reads and writes
    bus_wr(A_DIV, 32'd4, 3'b010);
    read_address = A_DIV;
    @(negedge clk);
    chk("map_div", read_data, 32'd4);
    read_address = BASE + 32'd1;
    @(negedge clk);
    chk("map_base1", read_data, 32'd0);
    read_address = A_DIV;
    @(negedge clk);
    read_address = BASE + 32'd12;
    @(negedge clk);
    chk("map_base12", read_data, 32'd0);
    read_address = A_IDLE;
    bus_wr(BASE + 32'd1, 32'h5A, 3'b010);
    bus_wr(BASE + 32'd12, 32'h5A, 3'b010);
    bus_wr(BASE + 32'd9, 32'd50, 3'b010);
    rd_chk("st_unmapped", A_STAT, 32'h04);
    rd_chk("div_unmapped", A_DIV, 32'd4);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("unmapped_no_tx", lows, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_FF00, the word-aligned base of the 3-register window.
REQ-002 SHALL have parameter BAUD_DIV, default 104, the reset value of the DIV register in clk cycles per bit (12 MHz / 115200).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, a power of two between 2 and 16.
REQ-004 SHALL use one clock and one reset: clk is the single clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock, the same domain as the memory bus.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 write_mem  input  1  bus write strobe, sampled on the clk rising edge.
REQ-008 write_address  input  32  bus write byte address.
REQ-009 write_data  input  32  bus write data.
REQ-010 funct3  input  3  access size: 000/100 byte, 001/101 half, 010 word.
REQ-011 read_address  input  32  bus read byte address.
REQ-012 read_data  output  32  registered read data; 0 when read_address is unmapped.
REQ-013 tx  output  1  serial line, idle high.

Function
REQ-014 Register map: BASE+0 DATA (write only, reads 0); BASE+4 STATUS (read only); BASE+8 DIV (read/write, bits [15:0]).
REQ-015 Address decode SHALL compare all 32 bits; other addresses SHALL cause no effect and return read_data 0.
REQ-016 A DATA write of any size SHALL push write_data[7:0] into the FIFO.
REQ-017 A DIV write SHALL take effect only when funct3 = 010; other sizes SHALL be ignored.
REQ-018 A written DIV value below 2 SHALL be stored as 2.
REQ-019 STATUS bit0 = busy (FSM not IDLE); bit1 = full; bit2 = empty; bit3 = overflow (sticky); bits[8:4] = FIFO count; all other bits 0.
REQ-020 read_data SHALL update on the clk edge after read_address is presented (1-cycle latency, same as bus memory).
REQ-021 A STATUS read SHALL clear overflow on the same edge it captures read_data; if an overflow event occurs on that edge, overflow SHALL remain set.
REQ-022 A DATA write while full with no pop on the same edge SHALL drop the byte and set overflow.
REQ-023 A push and a pop on the same edge SHALL both succeed, including when the FIFO is full.
REQ-024 FSM states: IDLE, START, DATA, STOP.
REQ-025 IDLE: if the FIFO is non-empty, pop the head into the shift register, latch DIV into the bit counter reload, and go to START on the same edge.
REQ-026 START: tx = 0 for DIV cycles, then go to DATA.
REQ-027 DATA: 8 bits LSB first, each held DIV cycles.
REQ-028 STOP: tx = 1 for DIV cycles, then go to IDLE.
REQ-029 Back-to-back frames SHALL have exactly one IDLE cycle between STOP and the next START.
REQ-030 A DIV write mid-frame SHALL NOT affect the current frame; it SHALL apply from the next frame.
REQ-031 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 The FIFO count SHALL saturate neither above FIFO_DEPTH nor below 0, per REQ-022 and REQ-023.
REQ-033 tx SHALL be registered; no combinational path from bus inputs to tx.

Reset
REQ-034 On reset assertion, immediately and independent of clk: tx = 1, read_data = 0, state = IDLE, FIFO empty (count 0), overflow = 0, DIV = BAUD_DIV, shift register = 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with tx returning high; queued bytes SHALL be discarded.
REQ-036 After reset deasserts, the first bus access SHALL be honoured on the first clk rising edge.

Verification
REQ-037 DIV = 4, write DATA 0x55 -> tx low for 4 cycles (start), then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles (stop); frame totals 40 cycles.
REQ-038 Write 9 bytes 0x01..0x09 back-to-back while the first frame is in flight (FIFO_DEPTH 8) -> all 9 transmitted in order, overflow stays 0. Then write 9 more with the FSM stalled at DIV 0xFFFF -> 8 queued, STATUS = full|overflow|busy with count 8; next STATUS read returns overflow = 1, the following read returns overflow = 0.
REQ-039 Write DIV = 0 (word) -> DIV reads back 2. Write DIV = 10 with funct3 = 000 -> DIV unchanged.
REQ-040 Write DIV = 8 during a frame sent at DIV 4 -> current frame keeps 4-cycle bits; the next frame uses 8-cycle bits; 1 IDLE cycle between frames.
REQ-041 Assert reset during DATA bit 3 of a frame with 3 bytes queued -> tx = 1 asynchronously, STATUS afterward = empty (0x04), nothing further transmitted.
REQ-042 Read BASE+12 and BASE+1 -> read_data 0 on the next edge, no state change; write to BASE+4 -> ignored.
